common_pseudo_lru_touch_sequencer: RTL and testbench

- Drives the touch side of a one-hot pseudo-LRU picker: it generates that picker's one-hot write address and write enable, and consumes its one-hot pick output.
- Queues cache-hit notifications from the access pipeline and presents them to the picker as at most one touch per cycle.
- Serves victim-allocation requests with a req/ack handshake. The allocated victim is sampled while the picker state is frozen, and is touched in that same cycle.

---
 rtl/common_pseudo_lru_touch_sequencer.sv | 132 +++++++++++++
 tb/tb_common_pseudo_lru_touch_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/common_pseudo_lru_touch_sequencer.sv
// rtl/common_pseudo_lru_touch_sequencer.sv - hit-queue drain and victim-allocation touch sequencer for a one-hot pseudo-LRU picker
module common_pseudo_lru_touch_sequencer #(
  parameter int SUBJECT_COUNT_LOG2 = 2,
  parameter int QUEUE_DEPTH_LOG2   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  hit_valid,
  output logic                                  hit_ready,
  input  logic [SUBJECT_COUNT_LOG2-1:0]         hit_addr,
  input  logic                                  alloc_req,
  output logic                                  alloc_ack,
  output logic [(1 << SUBJECT_COUNT_LOG2)-1:0]  alloc_addr,
  output logic                                  alloc_fail,
  input  logic [(1 << SUBJECT_COUNT_LOG2)-1:0]  pick_qaddr,
  output logic [(1 << SUBJECT_COUNT_LOG2)-1:0]  pick_waddr,
  output logic                                  pick_wen,
  output logic [QUEUE_DEPTH_LOG2:0]             queue_count
);

  localparam int P = 1 << SUBJECT_COUNT_LOG2;
  localparam int D = 1 << QUEUE_DEPTH_LOG2;
  localparam logic [QUEUE_DEPTH_LOG2:0] FULL_COUNT = (QUEUE_DEPTH_LOG2+1)'(D);
  localparam logic [QUEUE_DEPTH_LOG2:0] ONE_COUNT  = (QUEUE_DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SUBJECT_COUNT_LOG2-1:0] queue_mem [D];
  logic [QUEUE_DEPTH_LOG2-1:0]   head, tail, tail_last;
  logic [QUEUE_DEPTH_LOG2:0]     count;
  logic                          queue_empty, pop, tail_dup, push_store;
  logic [P-1:0]                  head_onehot;
  logic [P-1:0]                  victim;
  logic                          fail_flag;

  assign queue_count = count;
  assign queue_empty = (count == '0);
  assign hit_ready   = (count != FULL_COUNT);
  assign tail_last   = tail - QUEUE_DEPTH_LOG2'(1);

  // PICK freezes the picker state, so the queue only drains outside it.
  assign pop = (state != PICK) && !queue_empty;

  // A hit matching the newest queued entry adds nothing; but if that entry is
  // being popped this cycle it is no longer queued and the hit must be stored.
  assign tail_dup   = !queue_empty && (queue_mem[tail_last] == hit_addr)
                      && !(pop && (count == ONE_COUNT));
  assign push_store = hit_valid && hit_ready && !tail_dup;

  // Decode the head entry into the picker's one-hot touch address.
  always_comb begin
    head_onehot = '0;
    head_onehot[queue_mem[head]] = 1'b1;
  end

  // Hit FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < D; i++) queue_mem[i] <= '0;
    end else begin
      if (push_store) begin
        queue_mem[tail] <= hit_addr;
        tail            <= tail + QUEUE_DEPTH_LOG2'(1);
      end
      if (pop) head <= head + QUEUE_DEPTH_LOG2'(1);
      count <= count + (QUEUE_DEPTH_LOG2+1)'(push_store) - (QUEUE_DEPTH_LOG2+1)'(pop);
    end
  end

  // Allocation FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Capture the victim and whether any subject was valid while the picker is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      victim    <= '0;
      fail_flag <= 1'b0;
    end else if (state == PICK) begin
      victim    <= pick_qaddr;
      fail_flag <= (pick_qaddr == '0);
    end
  end

  // Next state and picker/allocation outputs; drain and victim touch never overlap.
  always_comb begin
    state_next = state;
    pick_wen   = 1'b0;
    pick_waddr = '0;
    alloc_ack  = 1'b0;
    alloc_addr = '0;
    alloc_fail = 1'b0;
    if (pop) begin
      pick_wen   = 1'b1;
      pick_waddr = head_onehot;
    end
    case (state)
      IDLE: begin
        if (alloc_req) state_next = PICK;
      end
      PICK: begin
        state_next = GRANT;
        if (pick_qaddr != '0) begin
          pick_wen   = 1'b1;
          pick_waddr = pick_qaddr;
        end
      end
      GRANT: begin
        state_next = IDLE;
        alloc_ack  = 1'b1;
        alloc_addr = victim;
        alloc_fail = fail_flag;
      end
      default: state_next = IDLE;
    endcase
  end

  // The picker must never present more than one candidate.
  a_pick_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(pick_qaddr));

endmodule

// File: tb/tb_common_pseudo_lru_touch_sequencer.sv
// tb/tb_common_pseudo_lru_touch_sequencer.sv - directed self-checking bench for common_pseudo_lru_touch_sequencer
module tb_common_pseudo_lru_touch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       hit_valid;
  logic       hit_ready;
  logic [1:0] hit_addr;
  logic       alloc_req;
  logic       alloc_ack;
  logic [3:0] alloc_addr;
  logic       alloc_fail;
  logic [3:0] pick_qaddr;
  logic [3:0] pick_waddr;
  logic       pick_wen;
  logic [2:0] queue_count;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle values for the fill-to-full run with alloc_req held (fail allocations).
  int         full_cnt   [14] = '{0, 1, 2, 2, 2, 3, 3, 3, 4, 3, 3, 2, 1, 0};
  logic       full_rdy   [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  logic       full_wen   [14] = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0};
  logic [3:0] full_waddr [14] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000,
                                  4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
  logic       full_ack   [14] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};

  common_pseudo_lru_touch_sequencer #(
    .SUBJECT_COUNT_LOG2(2),
    .QUEUE_DEPTH_LOG2  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_addr   (hit_addr),
    .alloc_req  (alloc_req),
    .alloc_ack  (alloc_ack),
    .alloc_addr (alloc_addr),
    .alloc_fail (alloc_fail),
    .pick_qaddr (pick_qaddr),
    .pick_waddr (pick_waddr),
    .pick_wen   (pick_wen),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input int cnt, input logic rdy, input logic wen,
                             input logic [3:0] waddr, input logic ack, input logic [3:0] aaddr,
                             input logic afail);
    #1;
    chk({tag, ".count"},      32'(queue_count), 32'(cnt));
    chk({tag, ".hit_ready"},  32'(hit_ready),   32'(rdy));
    chk({tag, ".pick_wen"},   32'(pick_wen),    32'(wen));
    chk({tag, ".pick_waddr"}, 32'(pick_waddr),  32'(waddr));
    chk({tag, ".alloc_ack"},  32'(alloc_ack),   32'(ack));
    chk({tag, ".alloc_addr"}, 32'(alloc_addr),  32'(aaddr));
    chk({tag, ".alloc_fail"}, 32'(alloc_fail),  32'(afail));
  endtask

  initial begin
    reset      = 1'b1;
    hit_valid  = 1'b0;
    hit_addr   = 2'd0;
    alloc_req  = 1'b0;
    pick_qaddr = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    reset = 1'b0;
    next();

    // Hit stream 2, 0, 3: one-cycle latency, occupancy never exceeds 1.
    hit_valid = 1'b1; hit_addr = 2'd2;
    check_cycle("hs0", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    next();
    hit_addr = 2'd0;
    check_cycle("hs1", 1, 1, 1, 4'b0100, 0, 4'b0000, 0);
    next();
    hit_addr = 2'd3;
    check_cycle("hs2", 1, 1, 1, 4'b0001, 0, 4'b0000, 0);
    next();
    hit_valid = 1'b0;
    check_cycle("hs3", 1, 1, 1, 4'b1000, 0, 4'b0000, 0);
    next();
    check_cycle("hs4", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);

    // Allocation with victim 0010; duplicate hit collapsed while PICK blocks the drain.
    alloc_req = 1'b1; pick_qaddr = 4'b0010; hit_valid = 1'b1; hit_addr = 2'd1;
    check_cycle("al0", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    next();
    alloc_req = 1'b0;
    check_cycle("al1", 1, 1, 1, 4'b0010, 0, 4'b0000, 0);
    next();
    hit_valid = 1'b0;
    check_cycle("al2", 1, 1, 1, 4'b0010, 1, 4'b0010, 0);
    next();
    // Same address pushed while its only copy pops: it must be stored again.
    hit_valid = 1'b1; hit_addr = 2'd2;
    check_cycle("al3", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    next();
    check_cycle("al4", 1, 1, 1, 4'b0100, 0, 4'b0000, 0);
    next();
    hit_valid = 1'b0;
    check_cycle("al5", 1, 1, 1, 4'b0100, 0, 4'b0000, 0);
    next();
    check_cycle("al6", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    next();

    // Back-to-back failing allocations while streaming hits until the queue fills.
    pick_qaddr = 4'b0000;
    for (int k = 0; k < 14; k++) begin
      hit_valid = (k < 10);
      hit_addr  = (k < 8) ? 2'(k % 4) : 2'd0;
      alloc_req = (k < 8);
      check_cycle($sformatf("full%0d", k), full_cnt[k], full_rdy[k], full_wen[k], full_waddr[k],
                  full_ack[k], 4'b0000, full_ack[k]);
      next();
    end

    // Reset asserted during PICK aborts the allocation and empties the queue.
    alloc_req = 1'b1; hit_valid = 1'b1; hit_addr = 2'd3; pick_qaddr = 4'b0100;
    check_cycle("rm0", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    next();
    hit_valid = 1'b0;
    check_cycle("rm1", 1, 1, 1, 4'b0100, 0, 4'b0000, 0);
    reset = 1'b1;
    check_cycle("rm_rst", 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
    next();
    reset = 1'b0; alloc_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_cycle($sformatf("rm_after%0d", k), 0, 1, 0, 4'b0000, 0, 4'b0000, 0);
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
